// File: rtl/data_memory_ctrl.sv
// Load/store data memory with byte/half/word accesses, sign/zero extension,
// a valid/ready request port, configurable wait states and access error reporting.
module data_memory_ctrl #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] BYTE_SPAN = 32'(DEPTH * 4);
  localparam logic [3:0]  WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t state, next_state;
  logic [3:0]  cnt;
  logic        cap_write;
  logic [31:0] cap_addr;
  logic [1:0]  cap_size;
  logic        cap_unsigned;
  logic [31:0] cap_wdata;

  logic [31:0] mem [DEPTH];

  logic        acc_write;
  logic [31:0] acc_addr;
  logic [1:0]  acc_size;
  logic        acc_unsigned;
  logic [31:0] acc_wdata;
  logic        do_access;
  logic        misalign;
  logic        acc_err;
  logic [AW-1:0] word_idx;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;
  logic [3:0]  byte_en;
  logic [31:0] lane_data;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (req_valid) next_state = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (cnt == 4'd0) next_state = ST_RESP;
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == ST_IDLE);
    resp_valid = (state == ST_RESP);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt          <= 4'd0;
      cap_write    <= 1'b0;
      cap_addr     <= 32'd0;
      cap_size     <= 2'd0;
      cap_unsigned <= 1'b0;
      cap_wdata    <= 32'd0;
    end else if (state == ST_IDLE && req_valid) begin
      cnt          <= WAIT_INIT;
      cap_write    <= req_write;
      cap_addr     <= req_addr;
      cap_size     <= req_size;
      cap_unsigned <= req_unsigned;
      cap_wdata    <= req_wdata;
    end else if (state == ST_WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // With no wait states the access happens on the accept edge, so it must use the live inputs.
  always_comb begin
    if (state == ST_IDLE) begin
      acc_write    = req_write;
      acc_addr     = req_addr;
      acc_size     = req_size;
      acc_unsigned = req_unsigned;
      acc_wdata    = req_wdata;
    end else begin
      acc_write    = cap_write;
      acc_addr     = cap_addr;
      acc_size     = cap_size;
      acc_unsigned = cap_unsigned;
      acc_wdata    = cap_wdata;
    end
    do_access = (state == ST_IDLE && req_valid && WAIT_STATES == 0) ||
                (state == ST_WAIT && cnt == 4'd0);
  end

  always_comb begin
    case (acc_size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = acc_addr[0];
      2'b10:   misalign = |acc_addr[1:0];
      default: misalign = 1'b1;
    endcase
    acc_err  = misalign || (acc_addr >= BYTE_SPAN);
    word_idx = acc_addr[AW+1:2];
    rd_word  = mem[word_idx];
  end

  always_comb begin
    case (acc_addr[1:0])
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (acc_size)
      2'b00:   load_data = acc_unsigned ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   load_data = acc_unsigned ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_data = rd_word;
    endcase
  end

  always_comb begin
    case (acc_size)
      2'b00: begin
        byte_en   = 4'b0001 << acc_addr[1:0];
        lane_data = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        byte_en   = 4'b0011 << acc_addr[1:0];
        lane_data = {2{acc_wdata[15:0]}};
      end
      2'b10: begin
        byte_en   = 4'b1111;
        lane_data = acc_wdata;
      end
      default: begin
        byte_en   = 4'b0000;
        lane_data = acc_wdata;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else if (do_access && acc_write && !acc_err) begin
      for (int b = 0; b < 4; b++)
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= lane_data[8*b +: 8];
    end
  end

  // Response data is registered on the edge entering RESP and held afterwards.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else if (do_access) begin
      resp_err   <= acc_err;
      resp_rdata <= (acc_err || acc_write) ? 32'd0 : load_data;
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: a zero-wait instance and a three-wait
// instance share the request inputs; each test drives one of them.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;

  logic        ready0, valid0, err0;
  logic [31:0] rdata0;
  logic        ready3, valid3, err3;
  logic [31:0] rdata3;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  data_memory_ctrl #(.DEPTH(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(ready0),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(valid0), .resp_rdata(rdata0), .resp_err(err0)
  );

  data_memory_ctrl #(.DEPTH(256), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(ready3),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(valid3), .resp_rdata(rdata3), .resp_err(err3)
  );

  always #5 clk = ~clk;

  // Issues one request, scrambles the inputs right after accept, and reports
  // response data, latency in edges after accept, and resp_valid one cycle later.
  task automatic access(input bit sel3, input logic wr, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat,
                        output logic vld_after);
    @(negedge clk);
    req_write = wr; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFC; req_size = 2'b11;
    req_write = ~wr; req_unsigned = ~uns; req_wdata = ~wd;
    lat = 0;
    while (!(sel3 ? valid3 : valid0) && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = sel3 ? rdata3 : rdata0;
    er = sel3 ? err3 : err0;
    @(posedge clk); #1;
    vld_after = sel3 ? valid3 : valid0;
  endtask

  task automatic test_reset();
    checks += 8;
    if (ready0 !== 1'b1)  begin fails++; $display("[TB] FAIL reset ready0 got %b expected 1", ready0); end
    if (valid0 !== 1'b0)  begin fails++; $display("[TB] FAIL reset valid0 got %b expected 0", valid0); end
    if (rdata0 !== 32'd0) begin fails++; $display("[TB] FAIL reset rdata0 got %h expected 0", rdata0); end
    if (err0 !== 1'b0)    begin fails++; $display("[TB] FAIL reset err0 got %b expected 0", err0); end
    if (ready3 !== 1'b1)  begin fails++; $display("[TB] FAIL reset ready3 got %b expected 1", ready3); end
    if (valid3 !== 1'b0)  begin fails++; $display("[TB] FAIL reset valid3 got %b expected 0", valid3); end
    if (rdata3 !== 32'd0) begin fails++; $display("[TB] FAIL reset rdata3 got %h expected 0", rdata3); end
    if (err3 !== 1'b0)    begin fails++; $display("[TB] FAIL reset err3 got %b expected 0", err3); end
  endtask

  task automatic test_store_load();
    vec_t v[6];
    logic [31:0] rd; logic er; int lat; logic va;
    v[0] = '{1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0000_0000, 1'b0};
    v[1] = '{1'b0, 32'h10, 2'b10, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0};
    v[2] = '{1'b1, 32'h11, 2'b00, 1'b0, 32'h12345680, 32'h0000_0000, 1'b0};
    v[3] = '{1'b0, 32'h10, 2'b10, 1'b0, 32'h0,        32'hDEAD80EF, 1'b0};
    v[4] = '{1'b0, 32'h11, 2'b00, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0};
    v[5] = '{1'b0, 32'h11, 2'b00, 1'b1, 32'h0,        32'h0000_0080, 1'b0};
    foreach (v[i]) begin
      access(1'b0, v[i].wr, v[i].addr, v[i].size, v[i].uns, v[i].wd, rd, er, lat, va);
      checks += 4;
      if (rd !== v[i].exp_rd)   begin fails++; $display("[TB] FAIL store_load[%0d] rdata got %h expected %h", i, rd, v[i].exp_rd); end
      if (er !== v[i].exp_err)  begin fails++; $display("[TB] FAIL store_load[%0d] err got %b expected %b", i, er, v[i].exp_err); end
      if (lat !== 0)            begin fails++; $display("[TB] FAIL store_load[%0d] latency got %0d expected 0", i, lat); end
      if (va !== 1'b0)          begin fails++; $display("[TB] FAIL store_load[%0d] pulse width resp_valid got %b expected 0", i, va); end
    end
  endtask

  task automatic test_half_misalign();
    vec_t v[6];
    logic [31:0] rd; logic er; int lat; logic va;
    v[0] = '{1'b0, 32'h12, 2'b01, 1'b0, 32'h0,       32'hFFFFDEAD, 1'b0};
    v[1] = '{1'b0, 32'h12, 2'b01, 1'b1, 32'h0,       32'h0000DEAD, 1'b0};
    v[2] = '{1'b1, 32'h13, 2'b01, 1'b0, 32'h0000FFFF, 32'h0000_0000, 1'b1};
    v[3] = '{1'b0, 32'h10, 2'b10, 1'b0, 32'h0,       32'hDEAD80EF, 1'b0};
    v[4] = '{1'b0, 32'h12, 2'b10, 1'b0, 32'h0,       32'h0000_0000, 1'b1};
    v[5] = '{1'b0, 32'h13, 2'b00, 1'b0, 32'h0,       32'hFFFFFFDE, 1'b0};
    foreach (v[i]) begin
      access(1'b0, v[i].wr, v[i].addr, v[i].size, v[i].uns, v[i].wd, rd, er, lat, va);
      checks += 3;
      if (rd !== v[i].exp_rd)  begin fails++; $display("[TB] FAIL half_misalign[%0d] rdata got %h expected %h", i, rd, v[i].exp_rd); end
      if (er !== v[i].exp_err) begin fails++; $display("[TB] FAIL half_misalign[%0d] err got %b expected %b", i, er, v[i].exp_err); end
      if (lat !== 0)           begin fails++; $display("[TB] FAIL half_misalign[%0d] latency got %0d expected 0", i, lat); end
    end
  endtask

  task automatic test_range();
    vec_t v[11];
    logic [31:0] rd; logic er; int lat; logic va;
    v[0]  = '{1'b0, 32'h3FC, 2'b10, 1'b0, 32'h0,        32'h0000_0000, 1'b0};
    v[1]  = '{1'b0, 32'h10,  2'b10, 1'b0, 32'h0,        32'hDEAD80EF, 1'b0};
    v[2]  = '{1'b0, 32'h400, 2'b10, 1'b0, 32'h0,        32'h0000_0000, 1'b1};
    v[3]  = '{1'b0, 32'h0,   2'b11, 1'b0, 32'h0,        32'h0000_0000, 1'b1};
    v[4]  = '{1'b1, 32'h400, 2'b10, 1'b0, 32'hCAFEF00D, 32'h0000_0000, 1'b1};
    v[5]  = '{1'b0, 32'h0,   2'b10, 1'b0, 32'h0,        32'h0000_0000, 1'b0};
    v[6]  = '{1'b0, 32'h10,  2'b10, 1'b0, 32'h0,        32'hDEAD80EF, 1'b0};
    v[7]  = '{1'b1, 32'h3FF, 2'b00, 1'b0, 32'hFFFFFF7F, 32'h0000_0000, 1'b0};
    v[8]  = '{1'b0, 32'h3FF, 2'b00, 1'b0, 32'h0,        32'h0000_007F, 1'b0};
    v[9]  = '{1'b0, 32'h3FE, 2'b01, 1'b1, 32'h0,        32'h0000_7F00, 1'b0};
    v[10] = '{1'b0, 32'h3FC, 2'b10, 1'b1, 32'h0,        32'h7F00_0000, 1'b0};
    foreach (v[i]) begin
      access(1'b0, v[i].wr, v[i].addr, v[i].size, v[i].uns, v[i].wd, rd, er, lat, va);
      checks += 2;
      if (rd !== v[i].exp_rd)  begin fails++; $display("[TB] FAIL range[%0d] rdata got %h expected %h", i, rd, v[i].exp_rd); end
      if (er !== v[i].exp_err) begin fails++; $display("[TB] FAIL range[%0d] err got %b expected %b", i, er, v[i].exp_err); end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic er; int lat; logic va;
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
    access(1'b1, 1'b1, 32'h8, 2'b10, 1'b0, 32'hA5A50001, rd, er, lat, va);
    checks += 3;
    if (lat !== 3)        begin fails++; $display("[TB] FAIL wait_store latency got %0d expected 3", lat); end
    if (er !== 1'b0)      begin fails++; $display("[TB] FAIL wait_store err got %b expected 0", er); end
    if (va !== 1'b0)      begin fails++; $display("[TB] FAIL wait_store pulse width resp_valid got %b expected 0", va); end
    access(1'b1, 1'b0, 32'h8, 2'b10, 1'b0, 32'h0, rd, er, lat, va);
    checks += 2;
    if (lat !== 3)            begin fails++; $display("[TB] FAIL wait_load latency got %0d expected 3", lat); end
    if (rd !== 32'hA5A50001)  begin fails++; $display("[TB] FAIL wait_load rdata got %h expected a5a50001", rd); end
    // Held request: accepts at k=0 and k=5, responses at k=3 and k=8.
    @(negedge clk);
    req_write = 1'b0; req_addr = 32'h8; req_size = 2'b10; req_unsigned = 1'b0; req_valid = 1'b1;
    checks++;
    if (ready3 !== 1'b1) begin fails++; $display("[TB] FAIL burst ready before accept got %b expected 1", ready3); end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      checks += 2;
      if (valid3 !== ((k % 5) == 3)) begin fails++; $display("[TB] FAIL burst[%0d] resp_valid got %b expected %b", k, valid3, (k % 5) == 3); end
      if (ready3 !== ((k % 5) == 4)) begin fails++; $display("[TB] FAIL burst[%0d] req_ready got %b expected %b", k, ready3, (k % 5) == 4); end
      if ((k % 5) == 3) begin
        checks++;
        if (rdata3 !== 32'hA5A50001) begin fails++; $display("[TB] FAIL burst[%0d] rdata got %h expected a5a50001", k, rdata3); end
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd; logic er; int lat; logic va;
    int stray;
    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h20; req_size = 2'b10; req_unsigned = 1'b0;
    req_wdata = 32'h12345678; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (ready3 !== 1'b0) begin fails++; $display("[TB] FAIL abort ready in wait got %b expected 0", ready3); end
    @(negedge clk); rstn = 1'b0;
    #1;
    checks += 4;
    if (ready3 !== 1'b1)  begin fails++; $display("[TB] FAIL abort ready got %b expected 1", ready3); end
    if (valid3 !== 1'b0)  begin fails++; $display("[TB] FAIL abort valid got %b expected 0", valid3); end
    if (rdata3 !== 32'd0) begin fails++; $display("[TB] FAIL abort rdata got %h expected 0", rdata3); end
    if (err3 !== 1'b0)    begin fails++; $display("[TB] FAIL abort err got %b expected 0", err3); end
    @(negedge clk); rstn = 1'b1;
    stray = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (valid3 === 1'b1) stray++;
    end
    checks++;
    if (stray !== 0) begin fails++; $display("[TB] FAIL abort stray resp_valid got %0d expected 0", stray); end
    access(1'b1, 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, rd, er, lat, va);
    checks += 2;
    if (rd !== 32'd0) begin fails++; $display("[TB] FAIL abort load 0x20 got %h expected 0", rd); end
    if (lat !== 3)    begin fails++; $display("[TB] FAIL abort load latency got %0d expected 3", lat); end
    access(1'b1, 1'b0, 32'h8, 2'b10, 1'b0, 32'h0, rd, er, lat, va);
    checks++;
    if (rd !== 32'd0) begin fails++; $display("[TB] FAIL abort load 0x8 cleared got %h expected 0", rd); end
  endtask

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0;
    req_size = 2'b00; req_unsigned = 1'b0; req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); rstn = 1'b1;
    test_store_load();
    test_half_misalign();
    test_range();
    test_wait_states();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout reached at %0t expected completion earlier", $time);
    $fatal(1, "[TB] timeout");
  end

endmodule
